// File: rtl/dragonfang_pkg.sv
// Shared core types: functional-unit count and the result packet broadcast on the CDB.
package dragonfang_pkg;

  localparam int unsigned NUMBER_FUNCTIONAL_UNITS = 4;
  localparam int unsigned WRITEBACK_BUFFER_DEPTH  = 2;
  localparam int unsigned TAG_WIDTH               = 6;
  localparam int unsigned DATA_WIDTH              = 32;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  destination_tag;
    logic [DATA_WIDTH-1:0] data;
  } data_packet_t;

endpackage

// File: rtl/result_fifo.sv
// Per-unit result FIFO; pointers carry one extra bit so full and empty are distinguishable.
module result_fifo
  import dragonfang_pkg::*;
#(
  parameter int unsigned DEPTH = WRITEBACK_BUFFER_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  data_packet_t push_packet,
  input  logic         pop,
  output data_packet_t head_packet,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  data_packet_t   mem_q [DEPTH];
  data_packet_t   mem_d [DEPTH];
  logic           push_en;
  logic           pop_en;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_packet = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign push_en     = push & ~full;
  assign pop_en      = pop & ~empty;

  // Next-state: write at tail, advance head; reset/clear empty the queue.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_packet;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
    if (reset || clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    mem_q    <= mem_d;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: buffers each unit's results and broadcasts one per cycle on the CDB.
module writeback_arbiter
  import dragonfang_pkg::data_packet_t;
  import dragonfang_pkg::WRITEBACK_BUFFER_DEPTH;
#(
  parameter int unsigned NUMBER_FUNCTIONAL_UNITS = dragonfang_pkg::NUMBER_FUNCTIONAL_UNITS,
  parameter int unsigned BUFFER_DEPTH            = WRITEBACK_BUFFER_DEPTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUMBER_FUNCTIONAL_UNITS-1:0] result_valid,
  input  data_packet_t                       result_packet [NUMBER_FUNCTIONAL_UNITS],
  output logic [NUMBER_FUNCTIONAL_UNITS-1:0] result_ready,
  output logic                               cdb_valid,
  output data_packet_t                       cdb_packet,
  output logic                               idle
);

  localparam int unsigned N     = NUMBER_FUNCTIONAL_UNITS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     fifo_empty;
  logic [N-1:0]     fifo_full;
  logic [N-1:0]     fifo_push;
  logic [N-1:0]     fifo_pop;
  data_packet_t     fifo_head [N];

  logic             grant_valid_c;
  logic [IDX_W-1:0] grant_idx_c;

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             cdb_valid_q, cdb_valid_d;
  data_packet_t     cdb_packet_q, cdb_packet_d;

  // Readiness ignores same-cycle dequeue so a full FIFO never accepts.
  assign result_ready = ~fifo_full & {N{~reset}};

  for (genvar i = 0; i < N; i++) begin : g_fifo
    assign fifo_push[i] = result_valid[i] & result_ready[i] & ~flush;
    assign fifo_pop[i]  = grant_valid_c & (grant_idx_c == IDX_W'(i)) & ~flush;

    result_fifo #(
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .clear       (flush),
      .push        (fifo_push[i]),
      .push_packet (result_packet[i]),
      .pop         (fifo_pop[i]),
      .head_packet (fifo_head[i]),
      .empty       (fifo_empty[i]),
      .full        (fifo_full[i])
    );
  end

  // Round-robin search starting just after the last granted unit.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    grant_valid_c = 1'b0;
    grant_idx_c   = last_grant_q;
    cand          = 0;
    cand_idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(last_grant_q) + k) % N;
      cand_idx = IDX_W'(cand);
      if (!grant_valid_c && !fifo_empty[cand_idx]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = cand_idx;
      end
    end
  end

  // Output register and grant pointer; flush drops the grant but keeps last_grant.
  always_comb begin
    last_grant_d = last_grant_q;
    cdb_valid_d  = grant_valid_c;
    cdb_packet_d = cdb_packet_q;
    if (grant_valid_c) begin
      last_grant_d = grant_idx_c;
      cdb_packet_d = fifo_head[grant_idx_c];
    end
    if (flush) begin
      last_grant_d = last_grant_q;
      cdb_valid_d  = 1'b0;
      cdb_packet_d = cdb_packet_q;
    end
    if (reset) begin
      last_grant_d = IDX_W'(N - 1);
      cdb_valid_d  = 1'b0;
      cdb_packet_d = '0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    last_grant_q <= last_grant_d;
    cdb_valid_q  <= cdb_valid_d;
    cdb_packet_q <= cdb_packet_d;
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_packet = cdb_packet_q;
  assign idle       = (&fifo_empty) & ~cdb_valid_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: per-unit expected queues checked by a bus monitor.
module tb_writeback_arbiter;
  import dragonfang_pkg::*;

  localparam int unsigned N = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic [N-1:0]       result_valid = '0;
  data_packet_t       result_packet [N];
  logic [N-1:0]       result_ready;
  logic               cdb_valid;
  data_packet_t       cdb_packet;
  logic               idle;

  int n_tests = 0;
  int n_fail  = 0;

  data_packet_t             exp_q [N][$];
  logic [TAG_WIDTH-1:0]     seen_tags [$];

  writeback_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .result_valid  (result_valid),
    .result_packet (result_packet),
    .result_ready  (result_ready),
    .cdb_valid     (cdb_valid),
    .cdb_packet    (cdb_packet),
    .idle          (idle)
  );

  always #5 clock = ~clock;

  // Bus monitor: every broadcast must be the oldest outstanding result of some unit.
  always @(negedge clock) begin
    bit hit;
    hit = 1'b0;
    if (cdb_valid === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (!hit && exp_q[i].size() > 0 && exp_q[i][0] === cdb_packet) begin
          void'(exp_q[i].pop_front());
          hit = 1'b1;
        end
      end
      n_tests++;
      if (!hit) begin
        n_fail++;
        $display("FAIL bus_packet: observed tag=%0h data=%h, required the head of a unit queue",
                 cdb_packet.destination_tag, cdb_packet.data);
      end
      seen_tags.push_back(cdb_packet.destination_tag);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int unsigned u, input logic [TAG_WIDTH-1:0] tag,
                     input logic [DATA_WIDTH-1:0] data, input bit expect_out);
    result_valid[u]  = 1'b1;
    result_packet[u] = '{destination_tag: tag, data: data};
    if (expect_out) exp_q[u].push_back(result_packet[u]);
  endtask

  task automatic clear_inputs();
    result_valid = '0;
  endtask

  task automatic clear_board();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    seen_tags.delete();
  endtask

  task automatic apply_reset();
    clear_inputs();
    flush = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_board();
  endtask

  task automatic wait_idle(input string name);
    bit done;
    int outstanding;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      if (idle === 1'b1) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: idle=%b, required 1 within 40 cycles", name, idle);
    end
    outstanding = 0;
    for (int i = 0; i < N; i++) outstanding += exp_q[i].size();
    n_tests++;
    if (outstanding !== 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results never broadcast, required 0", name, outstanding);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    result_valid = '1;
    tick();
    @(negedge clock);
    n_tests++;
    if (result_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: observed %b, required 0000", result_ready);
    end
    n_tests++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_cdb_valid: observed %b, required 0", cdb_valid);
    end
    n_tests++;
    if (cdb_packet !== '0) begin
      n_fail++; $display("FAIL reset_cdb_packet: observed %h, required 0", cdb_packet);
    end
    result_valid = '0;
    reset = 1'b0;
    tick();
    @(negedge clock);
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: observed %b, required 1", idle);
    end
    n_tests++;
    if (result_ready !== 4'b1111) begin
      n_fail++; $display("FAIL release_ready: observed %b, required 1111", result_ready);
    end
    clear_board();
  endtask

  task automatic test_single_latency();
    data_packet_t want;
    apply_reset();
    for (int k = 0; k < 6; k++) tick();
    want = '{destination_tag: 6'd5, data: 32'hDEADBEEF};
    put(2, 6'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clock);
    n_tests++;
    if (result_ready[2] !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: observed %b, required 1", result_ready[2]);
    end
    tick();
    clear_inputs();
    @(negedge clock);
    n_tests++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_n1_valid: observed %b, required 0", cdb_valid);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if (cdb_valid !== 1'b1 || cdb_packet !== want) begin
      n_fail++; $display("FAIL single_n2: observed valid=%b pkt=%h, required 1 %h", cdb_valid, cdb_packet, want);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if (cdb_valid !== 1'b0 || cdb_packet !== want) begin
      n_fail++; $display("FAIL single_n3_hold: observed valid=%b pkt=%h, required 0 %h", cdb_valid, cdb_packet, want);
    end
    wait_idle("single");
  endtask

  task automatic test_all_units();
    apply_reset();
    tick();
    for (int i = 0; i < N; i++) put(i, TAG_WIDTH'(i + 1), 32'h100 + 32'(i), 1'b1);
    tick();
    clear_inputs();
    tick();
    for (int k = 0; k < N; k++) begin
      @(negedge clock);
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_packet.destination_tag !== TAG_WIDTH'(k + 1)) begin
        n_fail++;
        $display("FAIL all_units_slot%0d: observed valid=%b tag=%0d, required 1 %0d",
                 k, cdb_valid, cdb_packet.destination_tag, k + 1);
      end
      tick();
    end
    wait_idle("all_units");
  endtask

  task automatic test_no_starvation();
    int idx;
    logic [TAG_WIDTH-1:0] seq;
    apply_reset();
    tick();
    seq = 6'h10;
    for (int s = 0; s < 8; s++) begin
      clear_inputs();
      if (result_ready[0] === 1'b1) begin
        put(0, seq, 32'h0A00 + 32'(s), 1'b1);
        seq = seq + 6'd1;
      end
      if (s == 1) put(3, 6'h3F, 32'hCAFE0003, 1'b1);
      tick();
    end
    clear_inputs();
    wait_idle("starvation");
    idx = -1;
    for (int k = 0; k < seen_tags.size(); k++)
      if (idx < 0 && seen_tags[k] === 6'h3F) idx = k;
    n_tests++;
    if (idx < 0 || idx > 1) begin
      n_fail++; $display("FAIL starvation_position: observed bus index %0d, required 0 or 1", idx);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    tick();
    put(0, 6'h20, 32'h20, 1'b1);
    put(2, 6'h22, 32'h22, 1'b1);
    put(3, 6'h23, 32'h23, 1'b1);
    put(1, 6'h11, 32'h1111, 1'b1);
    @(negedge clock);
    n_tests++;
    if (result_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_a0: observed %b, required 1", result_ready[1]);
    end
    tick();
    clear_inputs();
    put(1, 6'h12, 32'h1212, 1'b1);
    @(negedge clock);
    n_tests++;
    if (result_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_a1: observed %b, required 1", result_ready[1]);
    end
    tick();
    put(1, 6'h13, 32'h1313, 1'b0);
    @(negedge clock);
    n_tests++;
    if (result_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_full: observed %b, required 0", result_ready[1]);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if (result_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_reopen: observed %b, required 1", result_ready[1]);
    end
    exp_q[1].push_back(result_packet[1]);
    tick();
    clear_inputs();
    wait_idle("b2b");
  endtask

  task automatic test_flush();
    apply_reset();
    tick();
    put(1, 6'h31, 32'h31, 1'b0);
    put(2, 6'h32, 32'h32, 1'b0);
    put(3, 6'h33, 32'h33, 1'b0);
    tick();
    clear_inputs();
    put(0, 6'h30, 32'h30, 1'b0);
    put(1, 6'h34, 32'h34, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_inputs();
    @(negedge clock);
    n_tests++;
    if (cdb_valid !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL flush_next: observed valid=%b idle=%b, required 0 1", cdb_valid, idle);
    end
    for (int k = 0; k < 4; k++) tick();
    put(0, 6'h20, 32'h50, 1'b1);
    put(1, 6'h21, 32'h51, 1'b1);
    put(2, 6'h22, 32'h52, 1'b1);
    tick();
    clear_inputs();
    wait_idle("flush");
    n_tests++;
    if (seen_tags.size() != 3 || seen_tags[0] !== 6'h20 || seen_tags[1] !== 6'h21 || seen_tags[2] !== 6'h22) begin
      n_fail++; $display("FAIL flush_last_grant: observed %0d tags first=%h, required 20 21 22",
                         seen_tags.size(), (seen_tags.size() > 0) ? seen_tags[0] : 6'h0);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    tick();
    for (int i = 0; i < N; i++) put(i, 6'h00 + TAG_WIDTH'(i), 32'h600 + 32'(i), 1'b1);
    tick();
    for (int i = 0; i < N; i++) put(i, 6'h08 + TAG_WIDTH'(i), 32'h680 + 32'(i), 1'b1);
    tick();
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (result_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_ready: observed %b, required 0000", result_ready);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if (cdb_valid !== 1'b0 || result_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_state: observed valid=%b ready=%b, required 0 0000", cdb_valid, result_ready);
    end
    reset = 1'b0;
    clear_board();
    tick();
    @(negedge clock);
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL midreset_idle: observed %b, required 1", idle);
    end
    tick();
    put(3, 6'h33, 32'h733, 1'b1);
    put(0, 6'h30, 32'h730, 1'b1);
    tick();
    clear_inputs();
    wait_idle("midreset");
    n_tests++;
    if (seen_tags.size() < 1 || seen_tags[0] !== 6'h30) begin
      n_fail++; $display("FAIL midreset_first_grant: observed first tag %h, required 30",
                         (seen_tags.size() > 0) ? seen_tags[0] : 6'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) result_packet[i] = '0;
    test_reset();
    test_single_latency();
    test_all_units();
    test_no_starvation();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
